axis_fifo_param: RTL
====================

AXIS_FIFO_PARAM -- requirements
Module: axis_fifo_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data bits per word, >=1.
REQ-002 SHALL have parameter DEPTH, default 7: storage words, >=2; power of two not required.
REQ-003 SHALL have parameter AFULL, default DEPTH-1: almost_full threshold, 1..DEPTH.
REQ-004 SHALL have parameter AEMPTY, default 1: almost_empty threshold, 0..DEPTH-1.
REQ-005 SHALL define CW = clog2(DEPTH+1), giving 3 for the default DEPTH.
REQ-006 SHALL have port clock, input, 1: single clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port flush, input, 1: synchronous discard of all stored words.
REQ-009 SHALL have port idata, input, WIDTH: write data.
REQ-010 SHALL have port ivalid, input, 1: write request.
REQ-011 SHALL have port iready, output, 1: FIFO can accept a word.
REQ-012 SHALL have port odata, output, WIDTH: head-of-queue data.
REQ-013 SHALL have port ovalid, output, 1: odata is valid.
REQ-014 SHALL have port oready, input, 1: consumer accepts the word.
REQ-015 SHALL have port size, output, CW: number of stored words, 0..DEPTH.
REQ-016 SHALL have port almost_full, output, 1: size >= AFULL.
REQ-017 SHALL have port almost_empty, output, 1: size <= AEMPTY.

Function
REQ-018 SHALL accept a word (push) when ivalid && iready at a rising edge; idata is captured that edge.
REQ-019 SHALL release a word (pop) when ovalid && oready at a rising edge.
REQ-020 SHALL drive iready = (size != DEPTH) && !flush, combinationally from registered size and flush.
REQ-021 SHALL drive ovalid = (size != 0), with odata holding the oldest stored word (first-word fall-through).
REQ-022 SHALL give a push-to-ovalid latency of exactly one cycle: a word pushed into an empty FIFO at edge t appears on odata/ovalid after edge t.
REQ-023 SHALL keep odata stable while ovalid=1 and oready=0.
REQ-024 SHALL update size as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-025 SHALL allow simultaneous push and pop at any 0 < size < DEPTH without losing or reordering data.
REQ-026 SHALL allow no push when full (iready=0); a pop at full makes iready=1 the next cycle, with no same-cycle pass-through.
REQ-027 SHALL allow no pop when empty (ovalid=0); ovalid ignores a same-cycle push, with no bypass.
REQ-028 SHALL use read/write pointers that wrap from DEPTH-1 to 0 for any DEPTH, including non-power-of-two values.
REQ-029 SHALL, on flush=1 at an edge, set size to 0, reset both pointers to 0, and ignore any push or pop in that cycle; ovalid=0 after that edge.
REQ-030 SHALL register almost_full and almost_empty, or derive them from registered size, so they are glitch-free and consistent with size in the same cycle.
REQ-031 SHALL preserve strict FIFO order of all accepted words between flushes.

Reset
REQ-032 SHALL, on reset=1 and independent of clock, set size=0, both pointers=0, ovalid=0, iready=0 while reset is held, almost_full=0 and almost_empty=1.
REQ-033 SHALL, after reset deasserts, set iready=1 combinationally, with the first push possible at the next rising edge.
REQ-034 SHALL, on reset asserted mid-transfer, discard stored data; odata contents are don't-care while ovalid=0.
REQ-035 SHALL keep memory array contents unreset; only control state is reset.

Verification
REQ-036 Fill with defaults (WIDTH=8, DEPTH=7), oready=0, push 0x00..0x09 -> first 7 accepted; size 1..7; iready=0 at size=7; almost_full=1 from size 6; words 0x07..0x09 held off.
REQ-037 Drain after fill: oready=1 -> odata 0x00..0x06 in order, one per cycle; size 7..0; ovalid=0 after 7 pops; almost_empty=1 at size<=1.
REQ-038 Streaming with ivalid=oready=1 from empty -> after first edge size stays 1, one word per cycle out, 20-word sequence preserved, no gaps.
REQ-039 Wrap: push 5, pop 5, push 7, pop 7 with DEPTH=7 -> pointers wrap through index 6->0, output order correct, and size returns to 0.
REQ-040 Flush at size=4 with ivalid=1 and oready=1 in the same cycle -> size=0 and ovalid=0 next cycle; neither the pushed nor the popped word takes effect; the next push emerges first.
REQ-041 Asynchronous reset pulse between clock edges at size=3 -> size=0, ovalid=0 immediately; iready=0 until release; DEPTH=5 rerun of REQ-036/REQ-039 passes.

Source files
------------

// File: rtl/axis_fifo_param.sv
// Single-clock first-word-fall-through FIFO with AXI-Stream style handshakes,
// synchronous flush and occupancy flags. DEPTH need not be a power of two.
module axis_fifo_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 7,
    parameter int AFULL  = DEPTH - 1,
    parameter int AEMPTY = 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] idata,
    input  logic             ivalid,
    output logic             iready,
    output logic [WIDTH-1:0] odata,
    output logic             ovalid,
    input  logic             oready,
    output logic [CW-1:0]    size,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    size_q, size_d;
    logic             push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // iready is forced low while reset is held so no word is taken during reset
    assign iready       = (size_q != CW'(DEPTH)) && !flush && !reset;
    assign ovalid       = (size_q != '0);
    assign odata        = mem_q[rd_ptr_q];
    assign size         = size_q;
    assign almost_full  = (size_q >= CW'(AFULL));
    assign almost_empty = (size_q <= CW'(AEMPTY));

    assign push = ivalid && iready;
    assign pop  = ovalid && oready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        size_d   = size_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            size_d   = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   size_d = size_q + 1'b1;
                2'b01:   size_d = size_q - 1'b1;
                default: size_d = size_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            size_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            size_q   <= size_d;
        end
    end

    // Storage carries no reset; only the control state above is cleared.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= idata;
    end

endmodule
